// File: rtl/ball_locator.sv
// Bounding-box ball locator on a raw camera stream: measures every complete frame and
// publishes the box centre of pixels at or above a per-frame latched threshold.
module ball_locator #(
  parameter int COORD_W    = 11,
  parameter int MIN_PIXELS = 16
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic [11:0]        cam_d,
  input  logic               cam_fval,
  input  logic               cam_lval,
  input  logic [11:0]        threshold,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               ball_found,
  output logic               result_valid,
  output logic [15:0]        frame_cnt
);

  localparam int HIT_W = 2 * COORD_W;
  localparam logic [HIT_W-1:0]   MIN_HITS = HIT_W'(MIN_PIXELS);
  localparam logic [COORD_W-1:0] C_ONES   = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] C_ZERO   = {COORD_W{1'b0}};
  localparam logic [HIT_W-1:0]   H_ONES   = {HIT_W{1'b1}};

  typedef enum logic [1:0] {
    SYNC       = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2,
    PUBLISH    = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_fval_d;
  logic               r_lval_d;
  logic [11:0]        r_thr;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COORD_W-1:0] r_min_x;
  logic [COORD_W-1:0] r_max_x;
  logic [COORD_W-1:0] r_min_y;
  logic [COORD_W-1:0] r_max_y;
  logic [HIT_W-1:0]   r_hits;

  logic               w_pix;
  logic               w_hit;
  logic               w_found;
  logic [COORD_W:0]   w_sum_x;
  logic [COORD_W:0]   w_sum_y;
  logic [HIT_W-1:0]   w_hits_inc;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    sat_inc = (v == C_ONES) ? v : v + {{(COORD_W-1){1'b0}}, 1'b1};
  endfunction

  // LVAL only counts while FVAL is high
  assign w_pix      = cam_fval & cam_lval;
  assign w_hit      = w_pix & (cam_d >= r_thr);
  assign w_found    = (r_hits >= MIN_HITS);
  assign w_sum_x    = {1'b0, r_min_x} + {1'b0, r_max_x};
  assign w_sum_y    = {1'b0, r_min_y} + {1'b0, r_max_y};
  assign w_hits_inc = (r_hits == H_ONES) ? r_hits : r_hits + {{(HIT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state      <= SYNC;
      r_fval_d     <= 1'b0;
      r_lval_d     <= 1'b0;
      r_thr        <= 12'd0;
      r_x          <= C_ZERO;
      r_y          <= C_ZERO;
      r_min_x      <= C_ZERO;
      r_max_x      <= C_ZERO;
      r_min_y      <= C_ZERO;
      r_max_y      <= C_ZERO;
      r_hits       <= {HIT_W{1'b0}};
      ball_x       <= C_ZERO;
      ball_y       <= C_ZERO;
      ball_found   <= 1'b0;
      result_valid <= 1'b0;
      frame_cnt    <= 16'd0;
    end else begin
      r_fval_d     <= cam_fval;
      r_lval_d     <= w_pix;
      result_valid <= 1'b0;
      case (r_state)
        SYNC: begin
          if (!cam_fval) r_state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (cam_fval && !r_fval_d) begin
            r_state <= ACTIVE;
            r_thr   <= threshold;
            r_x     <= C_ZERO;
            r_y     <= C_ZERO;
            r_hits  <= {HIT_W{1'b0}};
            r_min_x <= C_ONES;
            r_min_y <= C_ONES;
            r_max_x <= C_ZERO;
            r_max_y <= C_ZERO;
          end
        end
        ACTIVE: begin
          if (w_hit) begin
            if (r_x < r_min_x) r_min_x <= r_x;
            if (r_x > r_max_x) r_max_x <= r_x;
            if (r_y < r_min_y) r_min_y <= r_y;
            if (r_y > r_max_y) r_max_y <= r_y;
            r_hits <= w_hits_inc;
          end
          // A line ends on LVAL falling or on FVAL dropping mid-line
          if (w_pix) begin
            r_x <= sat_inc(r_x);
          end else if (r_lval_d) begin
            r_x <= C_ZERO;
            r_y <= sat_inc(r_y);
          end
          if (!cam_fval) begin
            r_state      <= PUBLISH;
            result_valid <= 1'b1;
            ball_found   <= w_found;
            frame_cnt    <= frame_cnt + 16'd1;
            if (w_found) begin
              ball_x <= w_sum_x[COORD_W:1];
              ball_y <= w_sum_y[COORD_W:1];
            end
          end
        end
        PUBLISH: begin
          r_state <= WAIT_FRAME;
        end
        default: begin
          r_state <= SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_locator.sv
// Randomised frame-level bench for ball_locator: two instances (wide/strict and narrow/
// permissive) are compared against a per-frame bounding-box model.
module tb_ball_locator;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cam_d;
  logic        fval;
  logic        lval;
  logic [11:0] thr;

  logic [10:0] a_x, a_y;
  logic        a_found, a_rv;
  logic [15:0] a_fc;
  logic [4:0]  b_x, b_y;
  logic        b_found, b_rv;
  logic [15:0] b_fc;

  ball_locator #(.COORD_W(11), .MIN_PIXELS(16)) dut_a (
    .clk_clk(clk), .reset_reset(rst), .cam_d(cam_d), .cam_fval(fval), .cam_lval(lval),
    .threshold(thr), .ball_x(a_x), .ball_y(a_y), .ball_found(a_found),
    .result_valid(a_rv), .frame_cnt(a_fc));

  ball_locator #(.COORD_W(5), .MIN_PIXELS(1)) dut_b (
    .clk_clk(clk), .reset_reset(rst), .cam_d(cam_d), .cam_fval(fval), .cam_lval(lval),
    .threshold(thr), .ball_x(b_x), .ball_y(b_y), .ball_found(b_found),
    .result_valid(b_rv), .frame_cnt(b_fc));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int exp_pulses = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int     cw[2]  = '{11, 5};
  int     mp[2]  = '{16, 1};
  longint m_hits[2];
  int     m_mnx[2], m_mxx[2], m_mny[2], m_mxy[2];
  int     m_bx[2], m_by[2], m_found[2], m_fc[2];
  int     m_thr;

  always @(posedge clk) begin
    if (a_rv) pulses_a++;
    if (b_rv) pulses_b++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_bx[i] = 0; m_by[i] = 0; m_found[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic model_start(input int t);
    m_thr = t;
    for (int i = 0; i < 2; i++) begin
      m_hits[i] = 0;
      m_mnx[i] = 1 << 30; m_mny[i] = 1 << 30;
      m_mxx[i] = -1;      m_mxy[i] = -1;
    end
  endtask

  task automatic model_pixel(input int x, input int y, input int d);
    int cmax, xa, ya;
    longint hmax;
    if (d >= m_thr) begin
      for (int i = 0; i < 2; i++) begin
        cmax = (1 << cw[i]) - 1;
        hmax = (64'd1 << (2 * cw[i])) - 1;
        xa = (x > cmax) ? cmax : x;
        ya = (y > cmax) ? cmax : y;
        if (xa < m_mnx[i]) m_mnx[i] = xa;
        if (xa > m_mxx[i]) m_mxx[i] = xa;
        if (ya < m_mny[i]) m_mny[i] = ya;
        if (ya > m_mxy[i]) m_mxy[i] = ya;
        if (m_hits[i] < hmax) m_hits[i]++;
      end
    end
  endtask

  task automatic model_publish();
    for (int i = 0; i < 2; i++) begin
      m_found[i] = (m_hits[i] >= mp[i]) ? 1 : 0;
      if (m_found[i] != 0) begin
        m_bx[i] = (m_mnx[i] + m_mxx[i]) / 2;
        m_by[i] = (m_mny[i] + m_mxy[i]) / 2;
      end
      m_fc[i] = (m_fc[i] + 1) % 65536;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".a_x"},     32'(a_x),     32'(m_bx[0]));
    check_val({tag, ".a_y"},     32'(a_y),     32'(m_by[0]));
    check_val({tag, ".a_found"}, 32'(a_found), 32'(m_found[0]));
    check_val({tag, ".a_fc"},    32'(a_fc),    32'(m_fc[0]));
    check_val({tag, ".b_x"},     32'(b_x),     32'(m_bx[1]));
    check_val({tag, ".b_y"},     32'(b_y),     32'(m_by[1]));
    check_val({tag, ".b_found"}, 32'(b_found), 32'(m_found[1]));
    check_val({tag, ".b_fc"},    32'(b_fc),    32'(m_fc[1]));
  endtask

  // kind: 0 random box, 1 single hit at (2,1), 2 fifteen hits on row 1, 3 block x100..119 y200..219
  function automatic int gen_pix(input int kind, input int x, input int y, input int t,
                                 input int bx0, input int bx1, input int by0, input int by1);
    int r;
    case (kind)
      1: return (x == 2 && y == 1) ? 12'hFFF : 0;
      2: return (y == 1 && x < 15) ? 12'hFFF : 0;
      3: return (x >= 100 && x <= 119 && y >= 200 && y <= 219) ? 12'hFFF : 0;
      default: begin
        r = $urandom_range(0, 9);
        if (r == 0) return t;
        if (r == 1 && t > 0) return t - 1;
        if (x >= bx0 && x <= bx1 && y >= by0 && y <= by1) return $urandom_range(12'hC00, 12'hFFF);
        return $urandom_range(0, 12'h3FF);
      end
    endcase
  endfunction

  task automatic run_frame(input string tag, input int kind, input int w, input int h,
                           input int t, input int trunc_len, input bit chg, input int new_thr);
    int bx0, bx1, by0, by1, d;
    bx0 = $urandom_range(0, w - 1); bx1 = $urandom_range(bx0, w - 1);
    by0 = $urandom_range(0, h - 1); by1 = $urandom_range(by0, h - 1);
    for (int k = 0; k < 2 + int'($urandom_range(0, 2)); k++) begin
      fval = 1'b0; lval = 1'($urandom_range(0, 1)); cam_d = 12'($urandom); thr = 12'($urandom);
      tick();
    end
    thr = 12'(t); fval = 1'b1; lval = 1'b0; model_start(t);
    tick();
    for (int y = 0; y <= h; y++) begin
      for (int x = 0; x < ((y == h) ? trunc_len : w); x++) begin
        if (chg && y == h / 2 && x == w / 2) thr = 12'(new_thr);
        d = gen_pix(kind, x, y, t, bx0, bx1, by0, by1);
        cam_d = 12'(d); lval = 1'b1; model_pixel(x, y, d);
        tick();
      end
      if (y < h) begin
        lval = 1'b0; cam_d = 12'($urandom);
        tick();
      end
    end
    fval = 1'b0; lval = (trunc_len > 0) ? 1'b1 : 1'b0;
    tick();
    model_publish();
    exp_pulses++;
    check_val({tag, ".a_rv"}, 32'(a_rv), 32'd1);
    check_val({tag, ".b_rv"}, 32'(b_rv), 32'd1);
    check_outputs(tag);
    lval = 1'b0;
    tick();
    check_val({tag, ".a_rv_off"}, 32'(a_rv), 32'd0);
    check_val({tag, ".a_pulses"}, 32'(pulses_a), 32'(exp_pulses));
    check_val({tag, ".b_pulses"}, 32'(pulses_b), 32'(exp_pulses));
  endtask

  task automatic random_frame(input string tag);
    int w, h, t;
    w = $urandom_range(4, 40);
    h = $urandom_range(2, 36);
    t = $urandom_range(12'h400, 12'hBFF);
    run_frame(tag, 0, w, h, t, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, w - 1)) : 0,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)));
  endtask

  initial begin
    rst = 1'b1; fval = 1'b0; lval = 1'b0; cam_d = 12'd0; thr = 12'd0;
    model_reset();
    repeat (3) tick();
    check_outputs("reset");
    check_val("reset.a_rv", 32'(a_rv), 32'd0);
    check_val("reset.b_rv", 32'(b_rv), 32'd0);
    rst = 1'b0;
    tick();

    run_frame("single_hit", 1, 4, 4, 12'h800, 0, 1'b0, 0);
    run_frame("hits15_a",   2, 20, 3, 12'h800, 0, 1'b0, 0);
    run_frame("block",      3, 124, 222, 12'h800, 0, 1'b0, 0);
    run_frame("hits15_b",   2, 20, 3, 12'h800, 0, 1'b0, 0);
    run_frame("thr_change", 0, 24, 20, 12'h800, 0, 1'b1, 0);
    run_frame("thr_zero",   0, 24, 20, 12'h000, 0, 1'b0, 0);
    run_frame("trunc",      0, 30, 10, 12'h600, 17, 1'b0, 0);
    run_frame("after_trunc", 1, 4, 4, 12'h800, 0, 1'b0, 0);
    for (int i = 0; i < 30; i++) random_frame($sformatf("rand%0d", i));

    // Reset in the middle of a frame, released while FVAL is still high
    thr = 12'h800; fval = 1'b1; lval = 1'b0;
    tick();
    for (int x = 0; x < 20; x++) begin
      cam_d = 12'hFFF; lval = 1'b1;
      tick();
    end
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    for (int x = 0; x < 20; x++) begin
      cam_d = 12'hFFF; lval = (x % 10) != 9;
      tick();
    end
    fval = 1'b0; lval = 1'b0;
    tick();
    check_val("midreset.a_rv", 32'(a_rv), 32'd0);
    check_val("midreset.b_rv", 32'(b_rv), 32'd0);
    check_outputs("midreset");
    tick();
    check_val("midreset.a_pulses", 32'(pulses_a), 32'(exp_pulses));
    check_val("midreset.b_pulses", 32'(pulses_b), 32'(exp_pulses));

    run_frame("post_reset", 1, 4, 4, 12'h800, 0, 1'b0, 0);
    for (int i = 0; i < 5; i++) random_frame($sformatf("tail%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
